// File: rtl/hc_pkg.sv
// Shared SECDED Hamming(21,16)+overall-parity definitions for the encoder,
// the decoder and the bench model.
package hc_pkg;

  localparam int DATA_W = 16;
  localparam int CW_W   = 22;
  localparam int N_PAR  = 5;

  localparam int PAR_POS  [N_PAR]  = '{1, 2, 4, 8, 16};
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15,
                                       17, 18, 19, 20, 21};

  // Coverage of each parity bit: positions 1..21 whose index has bit k set,
  // excluding the parity position itself.
  localparam logic [CW_W-1:0] COVER_P0 = 22'h2AAAA8;
  localparam logic [CW_W-1:0] COVER_P1 = 22'h0CCCC8;
  localparam logic [CW_W-1:0] COVER_P2 = 22'h30F0E0;
  localparam logic [CW_W-1:0] COVER_P3 = 22'h00FE00;
  localparam logic [CW_W-1:0] COVER_P4 = 22'h3E0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [CW_W-1:0] hc_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    cw        = '0;
    cw[3]     = data[0];
    cw[7:5]   = data[3:1];
    cw[15:9]  = data[10:4];
    cw[21:17] = data[15:11];
    cw[1]     = ^(cw & COVER_P0);
    cw[2]     = ^(cw & COVER_P1);
    cw[4]     = ^(cw & COVER_P2);
    cw[8]     = ^(cw & COVER_P3);
    cw[16]    = ^(cw & COVER_P4);
    cw[0]     = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/hc_encode_comb.sv
// Combinational Hamming encoder; the decoder reuses it to recompute syndromes.
module hc_encode_comb
  import hc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  assign cw = hc_encode(data);

endmodule

// File: rtl/hc_encoder_serializer.sv
// Encodes 16-bit words into 22-bit SECDED codewords and shifts them out
// serially with valid/ready on both sides and sof/eof frame strobes.
module hc_encoder_serializer
  import hc_pkg::*;
#(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned FRAME_GAP = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              ser_eof,
  input  logic              ser_ready,
  output logic [CW_W-1:0]   cw_out,
  output logic              cw_valid,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam logic [3:0] GAP_LAST = (FRAME_GAP == 0) ? 4'd0 : 4'(FRAME_GAP - 1);

  state_t          state_q, state_d;
  logic [CW_W-1:0] sr_q, sr_next, enc_cw;
  logic [4:0]      bit_cnt_q;
  logic [3:0]      gap_cnt_q;
  logic            last_bit, frame_done, accept, xfer;

  hc_encode_comb u_encode (
    .data (in_data),
    .cw   (enc_cw)
  );

  assign last_bit = (bit_cnt_q == 5'd21);
  assign xfer     = ser_valid && ser_ready;
  assign sr_next  = LSB_FIRST ? {1'b0, sr_q[CW_W-1:1]} : {sr_q[CW_W-2:0], 1'b0};
  assign ser_out  = ser_valid && (LSB_FIRST ? sr_q[0] : sr_q[CW_W-1]);
  assign ser_sof  = ser_valid && (bit_cnt_q == 5'd0);
  assign ser_eof  = ser_valid && last_bit;
  assign busy     = (state_q != ST_IDLE);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    ser_valid  = 1'b0;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = 1'b1;
      ST_SHIFT: begin
        ser_valid  = 1'b1;
        frame_done = ser_ready && last_bit;
        if (FRAME_GAP == 0) in_ready = frame_done;
      end
      default: ;
    endcase
    // in_ready stays low while reset is held, rising in the first free cycle.
    in_ready = in_ready && !rst;
    accept   = in_ready && in_valid;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (frame_done)
                  state_d = accept ? ST_SHIFT : ((FRAME_GAP == 0) ? ST_IDLE : ST_GAP);
      ST_GAP:   if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cw_out    <= '0;
      cw_valid  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cw_valid <= accept;
      if (accept) begin
        sr_q      <= enc_cw;
        cw_out    <= enc_cw;
        bit_cnt_q <= '0;
      end else if (xfer) begin
        sr_q      <= sr_next;
        bit_cnt_q <= last_bit ? 5'd0 : bit_cnt_q + 5'd1;
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_hc_encoder_serializer.sv
// Directed and LFSR-driven bench for hc_encoder_serializer: LSB/MSB-first
// gap-0 instances share stimulus; a third instance uses a 4-cycle frame gap.
module tb_hc_encoder_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        ser_ready = 1'b0;
  logic [15:0] g_in_data = '0;
  logic        g_in_valid = 1'b0;
  logic        g_ser_ready = 1'b0;

  logic        a_in_ready, a_ser_out, a_ser_valid, a_ser_sof, a_ser_eof, a_cw_valid, a_busy;
  logic [21:0] a_cw_out;
  logic [15:0] a_frame_cnt;
  logic        m_in_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof, m_cw_valid, m_busy;
  logic [21:0] m_cw_out;
  logic [15:0] m_frame_cnt;
  logic        g_in_ready, g_ser_out, g_ser_valid, g_ser_sof, g_ser_eof, g_cw_valid, g_busy;
  logic [21:0] g_cw_out;
  logic [15:0] g_frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [21:0] rec_a, rec_m, rec_first_cw;
  int          rec_bits, rec_cycles, rec_flag_errs, rec_hold_errs, rec_cwv_cnt;
  logic        rec_ready, rec_first_valid, rec_first_sof;

  always #5 clk = ~clk;

  hc_encoder_serializer #(.LSB_FIRST(1'b1), .FRAME_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .ser_out(a_ser_out), .ser_valid(a_ser_valid), .ser_sof(a_ser_sof), .ser_eof(a_ser_eof),
    .ser_ready(ser_ready), .cw_out(a_cw_out), .cw_valid(a_cw_valid),
    .frame_cnt(a_frame_cnt), .busy(a_busy));

  hc_encoder_serializer #(.LSB_FIRST(1'b0), .FRAME_GAP(0)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
    .ser_out(m_ser_out), .ser_valid(m_ser_valid), .ser_sof(m_ser_sof), .ser_eof(m_ser_eof),
    .ser_ready(ser_ready), .cw_out(m_cw_out), .cw_valid(m_cw_valid),
    .frame_cnt(m_frame_cnt), .busy(m_busy));

  hc_encoder_serializer #(.LSB_FIRST(1'b1), .FRAME_GAP(4)) dut_g (
    .clk(clk), .rst(rst), .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .ser_out(g_ser_out), .ser_valid(g_ser_valid), .ser_sof(g_ser_sof), .ser_eof(g_ser_eof),
    .ser_ready(g_ser_ready), .cw_out(g_cw_out), .cw_valid(g_cw_valid),
    .frame_cnt(g_frame_cnt), .busy(g_busy));

  // Independent encoder: walks positions 1..21, data fills non-powers of two.
  function automatic logic [21:0] model_encode(input logic [15:0] d);
    logic [21:0] cw;
    int di;
    int par;
    cw = '0;
    di = 0;
    for (int p = 3; p < 22; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((d >> di) & 16'd1) != 16'd0) cw = cw | (22'd1 << p);
        di++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      par = 0;
      for (int p = 1; p < 22; p++)
        if (((p >> k) & 1) != 0 && ((cw >> p) & 22'd1) != 22'd0) par ^= 1;
      if (par != 0) cw = cw | (22'd1 << (1 << k));
    end
    par = 0;
    for (int p = 1; p < 22; p++)
      if (((cw >> p) & 22'd1) != 22'd0) par ^= 1;
    if (par != 0) cw = cw | 22'd1;
    return cw;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; g_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Sends one word into dut_a/dut_m and deserializes both frames; optional
  // stall of stall_len cycles when bit stall_at is presented.
  task automatic frame_a(input logic [15:0] d, input int stall_at, input int stall_len);
    int   stalls;
    int   last_idx;
    logic last_bit;
    rec_a = '0; rec_m = '0; rec_bits = 0; rec_cycles = 0;
    rec_flag_errs = 0; rec_hold_errs = 0; rec_cwv_cnt = 0;
    stalls = 0; last_idx = -1; last_bit = 1'b0;
    @(posedge clk); #1;
    in_data = d; in_valid = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    rec_ready = a_in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    while (rec_bits < 22 && rec_cycles < 100) begin
      ser_ready = !(rec_bits == stall_at && stalls < stall_len);
      @(negedge clk);
      if (rec_cycles == 0) begin
        rec_first_valid = a_ser_valid;
        rec_first_sof   = a_ser_sof;
        rec_first_cw    = a_cw_out;
      end
      if (a_cw_valid) rec_cwv_cnt++;
      if (a_ser_valid) begin
        if (a_ser_sof !== (rec_bits == 0) || a_ser_eof !== (rec_bits == 21)) rec_flag_errs++;
        if (last_idx == rec_bits && a_ser_out !== last_bit) rec_hold_errs++;
        last_idx = rec_bits;
        last_bit = a_ser_out;
        if (ser_ready) begin
          rec_a = rec_a | (22'(a_ser_out) << rec_bits);
          rec_m = rec_m | (22'(m_ser_out) << rec_bits);
          rec_bits++;
        end else begin
          stalls++;
        end
      end
      @(posedge clk); #1;
      rec_cycles++;
    end
    ser_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready);
    end
    checks++;
    if ({a_ser_out, a_ser_valid, a_ser_sof, a_ser_eof, a_cw_valid, a_busy} !== 6'b0 ||
        a_cw_out !== 22'h0 || a_frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b cw=%h cnt=%h expected all zero",
               {a_ser_out, a_ser_valid, a_ser_sof, a_ser_eof, a_cw_valid, a_busy},
               a_cw_out, a_frame_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || g_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: got a=%b g=%b busy=%b expected 1 1 0",
               a_in_ready, g_in_ready, a_busy);
    end
  endtask

  task automatic test_basic();
    frame_a(16'h0001, -1, 0);
    checks++;
    if (rec_ready !== 1'b1 || rec_first_valid !== 1'b1 || rec_first_sof !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got ready=%b valid=%b sof=%b expected 1 1 1",
               rec_ready, rec_first_valid, rec_first_sof);
    end
    checks++;
    if (rec_first_cw !== 22'h00000F || rec_cwv_cnt != 1) begin
      errors++;
      $display("FAIL basic_cw_out: got %h pulses=%0d expected 00000f pulses=1",
               rec_first_cw, rec_cwv_cnt);
    end
    checks++;
    if (rec_a !== 22'h00000F || rec_bits != 22 || rec_cycles != 22) begin
      errors++;
      $display("FAIL basic_serial_lsb: got %h bits=%0d cycles=%0d expected 00000f 22 22",
               rec_a, rec_bits, rec_cycles);
    end
    checks++;
    if (rec_m !== 22'h3C0000) begin
      errors++; $display("FAIL basic_serial_msb: got %h expected 3c0000", rec_m);
    end
    checks++;
    if (rec_flag_errs != 0) begin
      errors++; $display("FAIL basic_sof_eof: got %0d bad strobes expected 0", rec_flag_errs);
    end
    @(negedge clk);
    checks++;
    if (a_frame_cnt !== 16'd1 || a_ser_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame_cnt: got cnt=%0d valid=%b busy=%b expected 1 0 0",
               a_frame_cnt, a_ser_valid, a_busy);
    end
  endtask

  task automatic test_patterns();
    frame_a(16'hFFFF, -1, 0);
    checks++;
    if (rec_first_cw !== 22'h3FFFFC || rec_a !== 22'h3FFFFC || rec_m !== 22'h0FFFFF) begin
      errors++;
      $display("FAIL ffff_codeword: got cw=%h lsb=%h msb=%h expected 3ffffc 3ffffc 0fffff",
               rec_first_cw, rec_a, rec_m);
    end
    frame_a(16'h0000, -1, 0);
    checks++;
    if (rec_first_cw !== 22'h0 || rec_a !== 22'h0 || rec_bits != 22 || rec_cycles != 22 ||
        rec_flag_errs != 0) begin
      errors++;
      $display("FAIL zero_codeword: got cw=%h ser=%h bits=%0d cycles=%0d flags=%0d expected 0 0 22 22 0",
               rec_first_cw, rec_a, rec_bits, rec_cycles, rec_flag_errs);
    end
    @(negedge clk);
    checks++;
    if (a_frame_cnt !== 16'd3) begin
      errors++; $display("FAIL patterns_frame_cnt: got %0d expected 3", a_frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[$];
    logic [21:0] f0, f1, f2;
    logic        acc;
    int          wi, nbits, valid_cycles, bubbles, flag_errs, cyc;
    words = '{16'h1234, 16'hABCD, 16'h0F0F};
    f0 = '0; f1 = '0; f2 = '0;
    wi = 0; nbits = 0; valid_cycles = 0; bubbles = 0; flag_errs = 0; cyc = 0;
    apply_reset();
    in_data = words[0]; in_valid = 1'b1; ser_ready = 1'b1;
    while (nbits < 66 && cyc < 300) begin
      @(negedge clk);
      acc = a_in_ready && in_valid;
      if (a_ser_valid) begin
        valid_cycles++;
        if (a_ser_sof !== ((nbits % 22) == 0) || a_ser_eof !== ((nbits % 22) == 21)) flag_errs++;
        if (nbits < 22)      f0 = f0 | (22'(a_ser_out) << (nbits % 22));
        else if (nbits < 44) f1 = f1 | (22'(a_ser_out) << (nbits % 22));
        else                 f2 = f2 | (22'(a_ser_out) << (nbits % 22));
        nbits++;
      end else if (nbits > 0) begin
        bubbles++;
      end
      @(posedge clk); #1;
      if (acc) begin
        wi++;
        if (wi < 3) in_data = words[wi];
        else in_valid = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (valid_cycles != 66 || bubbles != 0 || flag_errs != 0) begin
      errors++;
      $display("FAIL b2b_stream: got valid=%0d bubbles=%0d flags=%0d expected 66 0 0",
               valid_cycles, bubbles, flag_errs);
    end
    checks++;
    if (f0 !== model_encode(words[0]) || f1 !== model_encode(words[1]) ||
        f2 !== model_encode(words[2])) begin
      errors++;
      $display("FAIL b2b_frames: got %h %h %h expected %h %h %h", f0, f1, f2,
               model_encode(words[0]), model_encode(words[1]), model_encode(words[2]));
    end
    @(negedge clk);
    checks++;
    if (a_frame_cnt !== 16'd3) begin
      errors++; $display("FAIL b2b_frame_cnt: got %0d expected 3", a_frame_cnt);
    end
  endtask

  task automatic test_frame_gap();
    logic [21:0] f0, f1;
    logic        acc;
    int          wi, nbits, cyc, gap_cycles, gap_ready, low_cycles;
    f0 = '0; f1 = '0;
    wi = 0; nbits = 0; cyc = 0; gap_cycles = 0; gap_ready = 0; low_cycles = 0;
    @(posedge clk); #1;
    g_in_data = 16'h0001; g_in_valid = 1'b1; g_ser_ready = 1'b1;
    while (nbits < 44 && cyc < 200) begin
      @(negedge clk);
      acc = g_in_ready && g_in_valid;
      if (nbits == 22) begin
        if (!g_ser_valid) low_cycles++;
        if (g_busy && !g_ser_valid) begin
          gap_cycles++;
          if (g_in_ready) gap_ready++;
        end
      end
      if (g_ser_valid && g_ser_ready) begin
        if (nbits < 22) f0 = f0 | (22'(g_ser_out) << nbits);
        else            f1 = f1 | (22'(g_ser_out) << (nbits - 22));
        nbits++;
      end
      @(posedge clk); #1;
      if (acc) begin
        wi++;
        if (wi < 2) g_in_data = 16'hFFFF;
        else begin g_in_valid = 1'b0; g_in_data = '0; end
      end
      cyc++;
    end
    // 4 GAP cycles, then one IDLE cycle in which the next word is accepted.
    checks++;
    if (gap_cycles != 4 || gap_ready != 0 || low_cycles != 5) begin
      errors++;
      $display("FAIL gap_length: got gap=%0d ready_in_gap=%0d low=%0d expected 4 0 5",
               gap_cycles, gap_ready, low_cycles);
    end
    checks++;
    if (f0 !== 22'h00000F || f1 !== 22'h3FFFFC) begin
      errors++; $display("FAIL gap_frames: got %h %h expected 00000f 3ffffc", f0, f1);
    end
    @(negedge clk);
    checks++;
    if (g_frame_cnt !== 16'd2) begin
      errors++; $display("FAIL gap_frame_cnt: got %0d expected 2", g_frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    frame_a(16'hA5C3, 10, 5);
    checks++;
    if (rec_a !== model_encode(16'hA5C3) || rec_bits != 22) begin
      errors++;
      $display("FAIL stall_frame: got %h bits=%0d expected %h bits=22",
               rec_a, rec_bits, model_encode(16'hA5C3));
    end
    checks++;
    if (rec_hold_errs != 0 || rec_flag_errs != 0 || rec_cycles != 27) begin
      errors++;
      $display("FAIL stall_hold: got hold=%0d flags=%0d cycles=%0d expected 0 0 27",
               rec_hold_errs, rec_flag_errs, rec_cycles);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   idx;
    logic reached;
    idx = 0; reached = 1'b0;
    @(posedge clk); #1;
    in_data = 16'hFFFF; in_valid = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      @(negedge clk);
      if (a_ser_valid && idx == 12) reached = 1'b1;
      else begin
        if (a_ser_valid) idx++;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (reached !== 1'b1 || a_ser_out !== 1'b1) begin
      errors++;
      $display("FAIL midreset_bit12: got reached=%b ser_out=%b expected 1 1", reached, a_ser_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_in_ready, a_ser_out, a_ser_valid, a_ser_sof, a_ser_eof, a_cw_valid, a_busy} !== 7'b0 ||
        a_cw_out !== 22'h0 || a_frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctl=%b cw=%h cnt=%0d expected all zero",
               {a_in_ready, a_ser_out, a_ser_valid, a_ser_sof, a_ser_eof, a_cw_valid, a_busy},
               a_cw_out, a_frame_cnt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_frame_cnt !== 16'd0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got ready=%b cnt=%0d busy=%b expected 1 0 0",
               a_in_ready, a_frame_cnt, a_busy);
    end
    frame_a(16'h0001, -1, 0);
    checks++;
    if (rec_first_sof !== 1'b1 || rec_a !== 22'h00000F || rec_flag_errs != 0) begin
      errors++;
      $display("FAIL midreset_next_frame: got sof=%b ser=%h flags=%0d expected 1 00000f 0",
               rec_first_sof, rec_a, rec_flag_errs);
    end
    @(negedge clk);
    checks++;
    if (a_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL midreset_frame_cnt: got %0d expected 1", a_frame_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] pending[$];
    logic [15:0] lfsr, exp_word;
    logic [21:0] cw;
    logic        acc;
    int          nbits, done, sent, cyc, flag_errs;
    lfsr = 16'hACE1; cw = '0;
    nbits = 0; done = 0; sent = 0; cyc = 0; flag_errs = 0;
    apply_reset();
    in_data = lfsr; in_valid = 1'b1; ser_ready = ($urandom_range(0, 3) != 0);
    while (done < 1000 && cyc < 60000) begin
      @(negedge clk);
      acc = a_in_ready && in_valid;
      if (a_cw_valid && pending.size() > 0) begin
        checks++;
        if (a_cw_out !== model_encode(pending[pending.size() - 1])) begin
          errors++;
          $display("FAIL rand_cw_out: got %h expected %h", a_cw_out,
                   model_encode(pending[pending.size() - 1]));
        end
      end
      if (a_ser_valid && (a_ser_sof !== (nbits == 0) || a_ser_eof !== (nbits == 21))) flag_errs++;
      if (a_ser_valid && ser_ready) begin
        cw = cw | (22'(a_ser_out) << nbits);
        nbits++;
        if (nbits == 22) begin
          exp_word = (pending.size() > 0) ? pending.pop_front() : 16'h0;
          checks++;
          if (cw !== model_encode(exp_word)) begin
            errors++;
            $display("FAIL rand_frame %0d: got %h expected %h", done, cw, model_encode(exp_word));
          end
          cw = '0; nbits = 0; done++;
        end
      end
      if (acc) begin pending.push_back(in_data); sent++; end
      @(posedge clk); #1;
      if (acc) begin
        lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        if (sent < 1000) in_data = lfsr;
        else in_valid = 1'b0;
      end
      ser_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    ser_ready = 1'b1;
    checks++;
    if (done != 1000 || flag_errs != 0) begin
      errors++;
      $display("FAIL rand_completion: got frames=%0d flags=%0d expected 1000 0", done, flag_errs);
    end
    @(negedge clk);
    checks++;
    if (a_frame_cnt !== 16'd1000) begin
      errors++; $display("FAIL rand_frame_cnt: got %0d expected 1000", a_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_frame_gap();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc_encoder_serializer.md
Name: hc_encoder_serializer

Overview:
- Consumes 16-bit data words from the pseudo-random word generator.
- Encodes each word as a 22-bit SECDED Hamming(21,16) codeword with an overall-parity bit.
- Shifts each codeword out one bit at a time, with a valid/ready handshake on both sides and a frame strobe.
- Feeds the channel/error-injection and decoder stages. It also publishes the parallel codeword so a checker can compare against it.

Parameters:
LSB_FIRST, 1, 1: serialize codeword bit 0 first; 0: bit 21 first
FRAME_GAP, 0, idle cycles inserted after each frame before a new word is accepted (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  16  data word to encode
in_valid  input  1  in_data valid; tie high when the source is a free-running LFSR
in_ready  output  1  block accepts in_data this cycle
ser_out  output  1  serial codeword bit
ser_valid  output  1  ser_out valid
ser_sof  output  1  high with the first bit of a frame
ser_eof  output  1  high with the last bit of a frame
ser_ready  input  1  downstream accepts ser_out this cycle
cw_out  output  22  codeword of the frame in flight; held until the next accept
cw_valid  output  1  one-cycle pulse the cycle after accept
frame_cnt  output  16  count of fully transmitted frames; wraps at 16'hFFFF->0
busy  output  1  state != IDLE

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - All outputs go to 0, with one exception: in_ready goes to 1 in the first cycle after reset deassertion (IDLE).
  - Shift register, bit counter, gap counter and frame_cnt are cleared.
  - Reset mid-frame drops the partial frame. frame_cnt is not incremented.
- Codeword layout: positions 0..21 map to cw bits 0..21.
  - Parity bits sit at positions 1, 2, 4, 8, 16.
  - Data bits fill the remaining positions in ascending order: d0->3, d1->5, d2->6, d3->7, d4..d10->9..15, d11..d15->17..21.
  - Each p_k (at position 2^k) is the even parity over all positions 1..21 whose index has bit k set.
  - Position 0 is the even parity over positions 1..21.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: in_ready=1. On in_valid, the word is accepted, encoded combinationally, and loaded into the 22-bit shift register. Next state is SHIFT and bit counter=0. cw_out updates and cw_valid pulses on the next cycle.
  - SHIFT: ser_valid=1. ser_out is the current bit (per LSB_FIRST). ser_sof=1 when counter==0; ser_eof=1 when counter==21. The bit advances only on ser_valid&&ser_ready. A stalled bit holds ser_out, ser_sof and ser_eof stable.
  - On the handshake of the counter==21 bit: frame_cnt+1. If FRAME_GAP==0, in_ready=1 in this same cycle for back-to-back frames; an accept goes directly to SHIFT with no bubble, otherwise to IDLE. If FRAME_GAP>0, the next state is GAP.
  - GAP: wait exactly FRAME_GAP cycles with ser_valid=0 and in_ready=0, then go to IDLE.
- Latency: accept at cycle N -> first bit with ser_valid at N+1. A frame takes 22 cycles when ser_ready is held high.
- in_ready is 0 in SHIFT, except on the last-bit handshake cycle when FRAME_GAP==0. in_data is ignored when in_ready=0.
- ser_ready has no effect outside SHIFT.

Decomposition:
- Package hc_pkg holds:
  - constants: DATA_W=16, CW_W=22, PAR_POS = {1,2,4,8,16}
  - the data-position map
  - function hc_encode(16)->22, shared with the future decoder and the testbench model
- One sub-module, hc_encode_comb: a purely combinational wrapper around hc_encode, reusable by the decoder for syndrome recompute.

Test Plan:
- Reset, then in_data=16'h0001, in_valid=1, ser_ready=1, LSB_FIRST=1 -> cw_out=22'h00000F. ser_out sequence is 1,1,1,1 followed by 18 zeros. ser_sof on the 1st bit, ser_eof on the 22nd. frame_cnt=1.
- in_data=16'hFFFF -> cw_out=22'h3FFFFC; bits 0..1 are 0 and bits 2..21 are 1. in_data=16'h0000 -> cw_out=0, with 22 zero bits still sent with ser_valid.
- Back-to-back: in_valid held high, FRAME_GAP=0, three words -> 66 consecutive ser_valid cycles, no bubble, frame_cnt=3. With FRAME_GAP=4 -> exactly 4 idle cycles between frames.
- Backpressure: drop ser_ready for 5 cycles at bit 10 -> ser_out held stable for those cycles, no bit lost or duplicated, frame still 22 bits.
- Reset asserted at bit 12 -> all outputs 0 immediately. After release, in_ready=1, frame_cnt=0, and the next frame starts from bit 0 with ser_sof.
- Random: 1000 LFSR words with randomized ser_ready -> deserialized stream matches hc_encode(in_data) for every frame; frame_cnt=1000.
